pccard_spi_master: RTL

- Byte-wide SPI master inside top. It drives the SS/SCLK/MOSI pins and samples MISO/INT of the external SPI slave.
- Upstream side is the PC Card register file (CE/OE/WE/IORD/IOWR decode). Software writes a byte and reads back the byte that was shifted in.
- Fixed SPI mode 0, MSB first. Slave select is software-controlled. INT is synchronised and edge-detected for the card interrupt logic.

---
 rtl/pccard_spi_master.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pccard_spi_master.sv
// Byte-wide SPI master (mode 0, MSB first) behind the PC Card register file.
// Also synchronises and edge-detects the slave's INT line.
module pccard_spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_52,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       ss_en,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  input  logic       INT,
  output logic       int_level,
  output logic       int_rise
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLow  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_q, rx_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            ss_q;
  logic            sync1_q, sync2_q, sync3_q;
  logic            div_tc;

  assign div_tc = (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    case (state_q)
      StIdle: begin
        if (tx_valid) begin
          shift_d = tx_data;
          bit_d   = 3'd0;
          div_d   = '0;
          mosi_d  = tx_data[7];
          state_d = StLow;
        end
      end
      StLow: begin
        if (div_tc) begin
          sclk_d  = 1'b1;
          shift_d = {shift_q[6:0], MISO};
          div_d   = '0;
          state_d = StHigh;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StHigh: begin
        if (div_tc) begin
          sclk_d = 1'b0;
          div_d  = '0;
          if (bit_q == 3'd7) begin
            // Shift register is already final here, so rx_data lands together with rx_valid.
            rx_d    = shift_q;
            state_d = StDone;
          end else begin
            bit_d   = bit_q + 3'd1;
            mosi_d  = shift_q[7];
            state_d = StLow;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StDone: begin
        mosi_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_52 or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      rx_q    <= 8'h00;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_q    <= ~ss_en;
      sync1_q <= INT;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign tx_ready  = (state_q == StIdle);
  assign rx_valid  = (state_q == StDone);
  assign rx_data   = rx_q;
  assign SS        = ss_q;
  assign SCLK      = sclk_q;
  assign MOSI      = mosi_q;
  assign int_level = sync2_q;
  assign int_rise  = sync2_q & ~sync3_q;

endmodule
